spi_reg_bank: RTL and testbench



---
 rtl/spi_reg_bank.sv | 206 ++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank -- SPI mode-0 peripheral exposing NUM_REGS registers of DATA_W bits.
// Frame, MSB first: R/W bit (1 = write), 7-bit address, then DATA_W data bits.
// A write commits on the ncs rising edge only when the frame has exactly the right length.
// Optional feature macro: SPI_READBACK_EN (read frames shift register data out on cipo).
module spi_reg_bank #(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FL    = 8 + DATA_W;
  localparam int CNT_W = $clog2(FL + 2);

  localparam logic [CNT_W-1:0] CNT_CMD    = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_FL     = CNT_W'(FL);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FL + 1);
  localparam logic [7:0]       NUM_REGS_8 = 8'(NUM_REGS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic                   ncs_prev_q, ncs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   armed_q, armed_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FL-1:0]          shift_in_q, shift_in_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
  logic                   frame_err_q, frame_err_d;

  logic                   ncs_s, sclk_s, copi_s;
  logic                   ncs_rise, sclk_rise;
  logic                   frame_rw, frame_end, len_ok, wr_hit;
  logic [6:0]             frame_addr;
  logic [DATA_W-1:0]      frame_data;

  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // ncs rising implies ncs_s high, so an sclk edge in the same cycle is dropped here
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~ncs_s;

  assign frame_rw   = shift_in_q[FL-1];
  assign frame_addr = shift_in_q[FL-2 -: 7];
  assign frame_data = shift_in_q[DATA_W-1:0];
  assign frame_end  = ncs_rise && (state_q != ST_IDLE);
  assign len_ok     = (cnt_q == CNT_FL);
  assign wr_hit     = frame_end && len_ok && frame_rw && ({1'b0, frame_addr} < NUM_REGS_8);

  // Synchroniser chains plus one history flop each for edge detection
  always_comb begin
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_prev_d  = ncs_s;
    sclk_prev_d = sclk_s;
    // A frame already running when reset drops is ignored until ncs is seen high
    armed_d     = armed_q | ncs_s;
  end

  // Frame FSM: bit counting and serial capture of the incoming frame
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_in_d = shift_in_q;
    if (ncs_rise) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (armed_q && !ncs_s) begin
        state_d = ST_CMD;
        cnt_d   = '0;
      end
    end else if (sclk_rise) begin
      shift_in_d = {shift_in_q[FL-2:0], copi_s};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_CMD) state_d = ST_DATA;
      else if (cnt_d == CNT_FL) state_d = ST_FULL;
    end
  end

  // End-of-frame commit: load the addressed register, pulse its strobe or flag a bad length
  always_comb begin
    frame_err_d = frame_end && !len_ok;
    wr_strobe_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit && (frame_addr == 7'(i))) begin
        regs_d[i]      = frame_data;
        wr_strobe_d[i] = 1'b1;
      end
    end
  end

  // State registers; ncs chain resets low so the first observed high arms the block
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_q  <= '0;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_in_q  <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_prev_q  <= ncs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_in_q  <= shift_in_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] shift_out_q, shift_out_d;
  logic [DATA_W-1:0] rd_data;
  logic              cipo_q, cipo_d;
  logic              sclk_fall;
  logic [7:0]        cmd_word;

  assign sclk_fall = ~sclk_s & sclk_prev_q & ~ncs_s;
  // Command byte as it will look once the 8th bit is shifted in
  assign cmd_word  = {shift_in_q[6:0], copi_s};

  // Load read data at the 8th rising edge; present one bit per data-phase falling edge
  always_comb begin
    rd_data     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_word[6:0] == 7'(i)) rd_data = regs_q[i];
    end
    shift_out_d = shift_out_q;
    cipo_d      = cipo_q;
    if (ncs_s) begin
      cipo_d = 1'b0;
    end else if (sclk_rise && (state_q == ST_CMD) && (cnt_q == CNT_W'(7))) begin
      shift_out_d = cmd_word[7] ? '0 : rd_data;
    end else if (sclk_fall) begin
      if (state_q == ST_DATA) begin
        cipo_d      = shift_out_q[DATA_W-1];
        shift_out_d = shift_out_q << 1;
      end else begin
        cipo_d = 1'b0;
      end
    end
  end

  // Shift-out and cipo registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_out_q <= '0;
      cipo_q      <= 1'b0;
    end else begin
      shift_out_q <= shift_out_d;
      cipo_q      <= cipo_d;
    end
  end

  assign cipo    = cipo_q;
  assign cipo_oe = armed_q & ~ncs_s;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank -- scoreboard bench for spi_reg_bank (NUM_REGS=5, DATA_W=8).
// Frames are driven on the pins; expected commit/error events are queued and a
// monitor compares them whenever the DUT pulses wr_strobe or frame_err.
`timescale 1ns/1ps
module tb_spi_reg_bank;
  localparam int NR   = 5;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 6;
  localparam int GAP  = 14;
  localparam logic [DW-1:0] RV = 8'h00;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ncs = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic cipo, cipo_oe, frame_err;
  logic [NR*DW-1:0] regs_flat;
  logic [NR-1:0]    wr_strobe;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .SYNC_STAGES(SS), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  typedef struct {
    logic [NR-1:0]    strobe;
    logic             err;
    logic [NR*DW-1:0] regs;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] mregs [NR];

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mregs[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every strobe/error pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && (wr_strobe !== '0 || frame_err !== 1'b0)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: strobe=%b err=%b, none expected", wr_strobe, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wr_strobe !== e.strobe || frame_err !== e.err || regs_flat !== e.regs) begin
          n_bad++;
          $display("FAIL event: strobe=%b err=%b regs=%h expected strobe=%b err=%b regs=%h",
                   wr_strobe, frame_err, regs_flat, e.strobe, e.err, e.regs);
        end
      end
    end
  end

  // Clock out edges [first,last) of frame vector fv; capture cipo before data-phase rising edges
  task automatic drive_edges(input logic [16:0] fv, input int first, input int last,
                             inout logic [DW-1:0] rd);
    for (int i = first; i < last; i++) begin
      copi = fv[16-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i <= 15) rd[15-i] = cipo;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    check("reset_regs", 64'(regs_flat), 64'({NR{RV}}));
    check("reset_strobe", 64'(wr_strobe), 64'(0));
    check("reset_err", 64'(frame_err), 64'(0));
    check("reset_cipo", 64'(cipo), 64'(0));
    check("reset_cipo_oe", 64'(cipo_oe), 64'(0));
  endtask

  // One full transaction: drive, predict from the model, then check the outcome
  task automatic frame(input logic rw, input logic [6:0] addr, input logic [DW-1:0] data,
                       input int nedges);
    logic [16:0]   fv;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rd;
    exp_t          e;
    int            a;
    a      = int'(addr);
    fv     = {rw, addr, data, 1'b0};
    rd     = '0;
    exp_rd = '0;
    if (RB && !rw && a < NR) exp_rd = mregs[a];
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    drive_edges(fv, 0, nedges, rd);
    check("cipo_oe_in_frame", 64'(cipo_oe), 64'(RB));
    repeat (HALF) @(negedge clk);
    e.strobe = '0;
    e.err    = 1'b0;
    if (nedges != 8 + DW) e.err = 1'b1;
    else if (rw && a < NR) begin
      mregs[a]    = data;
      e.strobe[a] = 1'b1;
    end
    e.regs = model_flat();
    if (e.err || e.strobe != '0) exp_q.push_back(e);
    ncs = 1'b1;
    repeat (GAP) @(negedge clk);
    check("pending_events", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    check("regs_after_frame", 64'(regs_flat), 64'(model_flat()));
    if (!rw && nedges == 8 + DW) check("read_data", 64'(rd), 64'(exp_rd));
    $display("frame rw=%0d addr=%0d data=%h edges=%0d regs=%h rd=%h",
             rw, addr, data, nedges, regs_flat, rd);
  endtask

  // Reset asserted partway through a write to reg1; the tail of that frame must be ignored
  task automatic reset_mid_frame();
    logic [16:0]   fv;
    logic [DW-1:0] rd;
    fv  = {1'b1, 7'd1, 8'h77, 1'b0};
    rd  = '0;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    drive_edges(fv, 0, 6, rd);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = RV;
    drive_edges(fv, 6, 16, rd);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (GAP) @(negedge clk);
    check("reset_frame_events", 64'(exp_q.size()), 64'(0));
    check("reset_frame_regs", 64'(regs_flat), 64'(model_flat()));
    $display("frame reset mid-write addr=1 data=77 regs=%h", regs_flat);
  endtask

  initial begin
    logic       rw;
    logic [6:0] addr;
    int         r, k, ne;
    for (int i = 0; i < NR; i++) mregs[i] = RV;
    repeat (4) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (8) @(negedge clk);

    frame(1'b1, 7'd2, 8'hA5, 16);
    frame(1'b1, 7'd0, 8'hFF, 12);
    frame(1'b1, 7'd3, 8'h11, 17);
    frame(1'b1, 7'd100, 8'h3C, 16);
    frame(1'b1, 7'd4, 8'h5A, 16);
    frame(1'b0, 7'd4, 8'h00, 16);
    frame(1'b0, 7'd7, 8'h00, 16);
    frame(1'b0, 7'd2, 8'h00, 12);
    reset_mid_frame();
    frame(1'b1, 7'd1, 8'h77, 16);
    frame(1'b0, 7'd1, 8'h00, 16);

    for (int n = 0; n < 40; n++) begin
      rw   = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      addr = (r < 8) ? 7'(r) : ((r == 8) ? 7'd100 : 7'd127);
      k    = int'($urandom_range(0, 5));
      ne   = (k <= 3) ? 16 : ((k == 4) ? int'($urandom_range(0, 15)) : 17);
      frame(rw, addr, 8'($urandom), ne);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
